// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: groups the decode-side, forwarding and EX-side signals of the ID/EX stage.
//   master : decode / hazard-source side (drives id_*, flush, mem_*, wb_*; sees stage outputs)
//   slave  : the id_ex_stage itself
// Parameters: WORD_W datapath width, OP_W opcode width, REG_ADDR_W register index width.
interface id_ex_stage_if #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned REG_ADDR_W = 3
);
    logic                  id_valid;
    logic [OP_W-1:0]       id_opcode;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic [REG_ADDR_W-1:0] id_rd;
    logic [WORD_W-1:0]     id_rs_data;
    logic [WORD_W-1:0]     id_rt_data;
    logic [WORD_W-1:0]     id_imm;
    logic                  flush;
    logic                  mem_wr_en;
    logic                  mem_load;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [WORD_W-1:0]     mem_result;
    logic                  wb_wr_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [WORD_W-1:0]     wb_result;

    logic                  id_stall;
    logic                  ex_valid;
    logic [OP_W-1:0]       ex_opcode;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_wr_en;
    logic                  ex_mem_read;
    logic                  ex_mem_write;
    logic [OP_W-1:0]       alu_sel;
    logic [WORD_W-1:0]     alu_data_1;
    logic [WORD_W-1:0]     alu_data_2;
    logic [WORD_W-1:0]     ex_store_data;

    modport master (
        output id_valid, id_opcode, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
        output flush, mem_wr_en, mem_load, mem_rd, mem_result, wb_wr_en, wb_rd, wb_result,
        input  id_stall, ex_valid, ex_opcode, ex_rd, ex_wr_en, ex_mem_read, ex_mem_write,
        input  alu_sel, alu_data_1, alu_data_2, ex_store_data
    );

    modport slave (
        input  id_valid, id_opcode, id_rs, id_rt, id_rd, id_rs_data, id_rt_data, id_imm,
        input  flush, mem_wr_en, mem_load, mem_rd, mem_result, wb_wr_en, wb_rd, wb_result,
        output id_stall, ex_valid, ex_opcode, ex_rd, ex_wr_en, ex_mem_read, ex_mem_write,
        output alu_sel, alu_data_1, alu_data_2, ex_store_data
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register and ALU operand-select stage.
//   Latches decoded instructions, maps opcodes to ALU select codes, forwards EX/MEM and MEM/WB
//   results onto the ALU operands, detects hazards (id_stall), inserts bubbles, honours flush.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - id_ex_stage_if.slave: decode fields, flush, MEM/WB forwarding sources in;
//          id_stall, ex_* fields, alu_sel, alu_data_1/2, ex_store_data out
// Configuration macro ID_EX_FORWARD_EN:
//   defined   - forwarding muxes, stall only on load-use
//   undefined - no forwarding, stall on any RAW match against EX or MEM
module id_ex_stage #(
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned OP_W       = 4,
    parameter int unsigned REG_ADDR_W = 3
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    localparam logic [OP_W-1:0] OpLw   = OP_W'(1);
    localparam logic [OP_W-1:0] OpLb   = OP_W'(2);
    localparam logic [OP_W-1:0] OpSw   = OP_W'(3);
    localparam logic [OP_W-1:0] OpSb   = OP_W'(4);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(5);
    localparam logic [OP_W-1:0] OpOr   = OP_W'(6);
    localparam logic [OP_W-1:0] OpAdd  = OP_W'(7);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(8);
    localparam logic [OP_W-1:0] OpSlt  = OP_W'(9);
    localparam logic [OP_W-1:0] OpBeq  = OP_W'(10);
    localparam logic [OP_W-1:0] OpJump = OP_W'(11);
    localparam logic [OP_W-1:0] OpAddi = OP_W'(12);

    // Decode of the ID-stage opcode
    logic [OP_W-1:0] dec_sel;
    logic            dec_wr_en, dec_mem_read, dec_mem_write, dec_use_imm;
    logic            rs_used, rt_used;

    always_comb begin
        dec_sel       = '0;
        dec_wr_en     = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_use_imm   = 1'b0;
        rs_used       = 1'b1;
        rt_used       = 1'b0;
        case (bus.id_opcode)
            OpLw, OpLb: begin
                dec_sel = OpAdd; dec_wr_en = 1'b1; dec_mem_read = 1'b1; dec_use_imm = 1'b1;
            end
            OpSw, OpSb: begin
                dec_sel = OpAdd; dec_mem_write = 1'b1; dec_use_imm = 1'b1; rt_used = 1'b1;
            end
            OpAnd, OpOr, OpAdd, OpSub, OpSlt: begin
                dec_sel = bus.id_opcode; dec_wr_en = 1'b1; rt_used = 1'b1;
            end
            OpBeq: begin
                dec_sel = OpSub; rt_used = 1'b1;
            end
            OpAddi: begin
                dec_sel = OpAdd; dec_wr_en = 1'b1; dec_use_imm = 1'b1;
            end
            OpJump:  rs_used = 1'b0;
            default: ;
        endcase
        if (bus.id_rd == '0) dec_wr_en = 1'b0;
    end

    // EX-stage registers
    logic                  ex_valid_q, ex_wr_en_q, ex_mem_read_q, ex_mem_write_q, use_imm_q;
    logic [OP_W-1:0]       ex_opcode_q, alu_sel_q;
    logic [REG_ADDR_W-1:0] ex_rd_q, rs_q, rt_q;
    logic [WORD_W-1:0]     rs_data_q, rt_data_q, imm_q;

    // Hazard detection against the instruction now in EX (and MEM when not forwarding)
    logic src_ex_match, hazard;

    always_comb begin
        src_ex_match = (rs_used && bus.id_rs == ex_rd_q) || (rt_used && bus.id_rt == ex_rd_q);
        hazard = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) && src_ex_match;
`ifndef ID_EX_FORWARD_EN
        // Without forwarding a result is only visible once it reaches WB (write-first regfile)
        if (ex_wr_en_q && (ex_rd_q != '0) && src_ex_match) hazard = 1'b1;
        if ((bus.mem_wr_en || bus.mem_load) && (bus.mem_rd != '0) &&
            ((rs_used && bus.id_rs == bus.mem_rd) || (rt_used && bus.id_rt == bus.mem_rd)))
            hazard = 1'b1;
`endif
    end

    assign bus.id_stall = bus.id_valid && !bus.flush && hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || 1'b0) begin
            ex_valid_q <= 1'b0; ex_opcode_q <= '0; ex_rd_q <= '0; ex_wr_en_q <= 1'b0;
            ex_mem_read_q <= 1'b0; ex_mem_write_q <= 1'b0; alu_sel_q <= '0; use_imm_q <= 1'b0;
            rs_q <= '0; rt_q <= '0; rs_data_q <= '0; rt_data_q <= '0; imm_q <= '0;
        end else if (bus.flush || bus.id_stall || !bus.id_valid) begin
            // Bubble
            ex_valid_q <= 1'b0; ex_opcode_q <= '0; ex_rd_q <= '0; ex_wr_en_q <= 1'b0;
            ex_mem_read_q <= 1'b0; ex_mem_write_q <= 1'b0; alu_sel_q <= '0; use_imm_q <= 1'b0;
            rs_q <= '0; rt_q <= '0; rs_data_q <= '0; rt_data_q <= '0; imm_q <= '0;
        end else begin
            ex_valid_q <= 1'b1; ex_opcode_q <= bus.id_opcode; ex_rd_q <= bus.id_rd;
            ex_wr_en_q <= dec_wr_en; ex_mem_read_q <= dec_mem_read;
            ex_mem_write_q <= dec_mem_write; alu_sel_q <= dec_sel; use_imm_q <= dec_use_imm;
            rs_q <= bus.id_rs; rt_q <= bus.id_rt;
            rs_data_q <= bus.id_rs_data; rt_data_q <= bus.id_rt_data; imm_q <= bus.id_imm;
        end
    end

    // Operand forwarding: MEM beats WB beats latched register data
    logic [WORD_W-1:0] rs_fwd, rt_fwd;

`ifdef ID_EX_FORWARD_EN
    function automatic logic [WORD_W-1:0] fwd(
        input logic [REG_ADDR_W-1:0] src,
        input logic [WORD_W-1:0]     latched,
        input logic                  m_en,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic [WORD_W-1:0]     m_data,
        input logic                  w_en,
        input logic [REG_ADDR_W-1:0] w_rd,
        input logic [WORD_W-1:0]     w_data
    );
        if (src == '0)                  return latched;
        if (m_en && m_rd == src)        return m_data;
        if (w_en && w_rd == src)        return w_data;
        return latched;
    endfunction

    always_comb begin
        rs_fwd = fwd(rs_q, rs_data_q, bus.mem_wr_en, bus.mem_rd, bus.mem_result,
                     bus.wb_wr_en, bus.wb_rd, bus.wb_result);
        rt_fwd = fwd(rt_q, rt_data_q, bus.mem_wr_en, bus.mem_rd, bus.mem_result,
                     bus.wb_wr_en, bus.wb_rd, bus.wb_result);
    end
`else
    assign rs_fwd = rs_data_q;
    assign rt_fwd = rt_data_q;
`endif

    assign bus.ex_valid      = ex_valid_q;
    assign bus.ex_opcode     = ex_opcode_q;
    assign bus.ex_rd         = ex_rd_q;
    assign bus.ex_wr_en      = ex_wr_en_q;
    assign bus.ex_mem_read   = ex_mem_read_q;
    assign bus.ex_mem_write  = ex_mem_write_q;
    assign bus.alu_sel       = alu_sel_q;
    assign bus.alu_data_1    = rs_fwd;
    assign bus.alu_data_2    = use_imm_q ? imm_q : rt_fwd;
    assign bus.ex_store_data = rt_fwd;
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table for opcode decode plus directed sequences
// for reset, forwarding, load-use stall, flush and RAW stalls. Works with or without
// ID_EX_FORWARD_EN defined.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.WORD_W(16), .OP_W(4), .REG_ADDR_W(3)) bus ();

    id_ex_stage #(.WORD_W(16), .OP_W(4), .REG_ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid = 1'b0; bus.id_opcode = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
        bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0; bus.flush = 1'b0;
        bus.mem_wr_en = 1'b0; bus.mem_load = 1'b0; bus.mem_rd = '0; bus.mem_result = '0;
        bus.wb_wr_en = 1'b0; bus.wb_rd = '0; bus.wb_result = '0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input logic [15:0] rs_d,
                         input logic [15:0] rt_d, input logic [15:0] imm);
        bus.id_valid = 1'b1; bus.id_opcode = op; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = rs_d; bus.id_rt_data = rt_d; bus.id_imm = imm;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".ex_valid"}, 32'(bus.ex_valid), 0);
        check({tag, ".ex_opcode"}, 32'(bus.ex_opcode), 0);
        check({tag, ".ex_rd"}, 32'(bus.ex_rd), 0);
        check({tag, ".ex_wr_en"}, 32'(bus.ex_wr_en), 0);
        check({tag, ".ex_mem_read"}, 32'(bus.ex_mem_read), 0);
        check({tag, ".ex_mem_write"}, 32'(bus.ex_mem_write), 0);
        check({tag, ".alu_sel"}, 32'(bus.alu_sel), 0);
        check({tag, ".alu_data_1"}, 32'(bus.alu_data_1), 0);
        check({tag, ".alu_data_2"}, 32'(bus.alu_data_2), 0);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  rs, rt, rd;
        logic [15:0] rs_d, rt_d, imm;
        logic [3:0]  sel;
        logic [15:0] d1, d2;
        logic        wr, mr, mw;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // op     rs    rt    rd    rs_d      rt_d      imm       sel   d1        d2      wr mr mw
        vecs[0]  = '{4'h7, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0000, 4'h7, 16'h0005, 16'h0003, 1, 0, 0};
        vecs[1]  = '{4'h8, 3'd1, 3'd2, 3'd3, 16'h0009, 16'h0004, 16'h0000, 4'h8, 16'h0009, 16'h0004, 1, 0, 0};
        vecs[2]  = '{4'h5, 3'd4, 3'd5, 3'd6, 16'hF0F0, 16'hFF00, 16'h0000, 4'h5, 16'hF0F0, 16'hFF00, 1, 0, 0};
        vecs[3]  = '{4'h6, 3'd4, 3'd5, 3'd6, 16'h00F0, 16'h0F00, 16'h0000, 4'h6, 16'h00F0, 16'h0F00, 1, 0, 0};
        vecs[4]  = '{4'h9, 3'd1, 3'd2, 3'd7, 16'h0001, 16'h0002, 16'h0000, 4'h9, 16'h0001, 16'h0002, 1, 0, 0};
        vecs[5]  = '{4'h1, 3'd1, 3'd2, 3'd4, 16'h0100, 16'h7777, 16'h0004, 4'h7, 16'h0100, 16'h0004, 1, 1, 0};
        vecs[6]  = '{4'h2, 3'd1, 3'd2, 3'd5, 16'h0100, 16'h7777, 16'h0003, 4'h7, 16'h0100, 16'h0003, 1, 1, 0};
        vecs[7]  = '{4'h3, 3'd1, 3'd2, 3'd0, 16'h0200, 16'hABCD, 16'h0008, 4'h7, 16'h0200, 16'h0008, 0, 0, 1};
        vecs[8]  = '{4'h4, 3'd1, 3'd2, 3'd0, 16'h0200, 16'h00CD, 16'h0001, 4'h7, 16'h0200, 16'h0001, 0, 0, 1};
        vecs[9]  = '{4'hA, 3'd1, 3'd2, 3'd0, 16'h0005, 16'h0005, 16'h0010, 4'h8, 16'h0005, 16'h0005, 0, 0, 0};
        vecs[10] = '{4'hB, 3'd0, 3'd0, 3'd0, 16'h1234, 16'h5678, 16'h0040, 4'h0, 16'h1234, 16'h5678, 0, 0, 0};
        vecs[11] = '{4'hC, 3'd1, 3'd0, 3'd0, 16'h0010, 16'h0000, 16'hFFFE, 4'h7, 16'h0010, 16'hFFFE, 0, 0, 0};
        vecs[12] = '{4'hC, 3'd1, 3'd0, 3'd2, 16'h0010, 16'h0000, 16'h0010, 4'h7, 16'h0010, 16'h0010, 1, 0, 0};
        vecs[13] = '{4'hF, 3'd1, 3'd2, 3'd3, 16'h0011, 16'h0022, 16'h0000, 4'h0, 16'h0011, 16'h0022, 0, 0, 0};
        vecs[14] = '{4'h7, 3'd1, 3'd2, 3'd0, 16'h0005, 16'h0003, 16'h0000, 4'h7, 16'h0005, 16'h0003, 0, 0, 0};

        idle();
        #1;
        check_zero("reset");
        check("reset.id_stall", 32'(bus.id_stall), 0);
        tick(); tick();
        rst = 1'b0;

        // Decode table; a bubble cycle separates entries so no hazard is possible
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd,
                  vecs[i].rs_d, vecs[i].rt_d, vecs[i].imm);
            #1;
            check($sformatf("v%0d.id_stall", i), 32'(bus.id_stall), 0);
            tick();
            check($sformatf("v%0d.ex_valid", i), 32'(bus.ex_valid), 1);
            check($sformatf("v%0d.ex_opcode", i), 32'(bus.ex_opcode), 32'(vecs[i].op));
            check($sformatf("v%0d.ex_rd", i), 32'(bus.ex_rd), 32'(vecs[i].rd));
            check($sformatf("v%0d.alu_sel", i), 32'(bus.alu_sel), 32'(vecs[i].sel));
            check($sformatf("v%0d.alu_data_1", i), 32'(bus.alu_data_1), 32'(vecs[i].d1));
            check($sformatf("v%0d.alu_data_2", i), 32'(bus.alu_data_2), 32'(vecs[i].d2));
            check($sformatf("v%0d.store_data", i), 32'(bus.ex_store_data), 32'(vecs[i].rt_d));
            check($sformatf("v%0d.ex_wr_en", i), 32'(bus.ex_wr_en), 32'(vecs[i].wr));
            check($sformatf("v%0d.ex_mem_read", i), 32'(bus.ex_mem_read), 32'(vecs[i].mr));
            check($sformatf("v%0d.ex_mem_write", i), 32'(bus.ex_mem_write), 32'(vecs[i].mw));
            idle();
            tick();
        end
        check_zero("bubble");

        // Asynchronous reset mid-stream, then first ADD one cycle after release
        drive(4'h7, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0000);
        tick();
        check("prerst.ex_valid", 32'(bus.ex_valid), 1);
        idle();
        #2 rst = 1'b1;
        #1;
        check_zero("async_rst");
        #1 rst = 1'b0;
        drive(4'h7, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0000);
        tick();
        check("postrst.alu_sel", 32'(bus.alu_sel), 7);
        check("postrst.alu_data_1", 32'(bus.alu_data_1), 16'h0005);
        check("postrst.alu_data_2", 32'(bus.alu_data_2), 16'h0003);
        check("postrst.ex_wr_en", 32'(bus.ex_wr_en), 1);
        idle();
        tick();

        // Forwarding priority on an ADD with rs=2 (latched 0x1111), rt=5 (latched 0x2222)
        drive(4'h7, 3'd2, 3'd5, 3'd6, 16'h1111, 16'h2222, 16'h0000);
        tick();
        idle();
        bus.mem_wr_en = 1'b1; bus.mem_rd = 3'd2; bus.mem_result = 16'h00AA;
        bus.wb_wr_en = 1'b1; bus.wb_rd = 3'd2; bus.wb_result = 16'h0055;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd.mem", 32'(bus.alu_data_1), 16'h00AA);
`else
        check("fwd.mem", 32'(bus.alu_data_1), 16'h1111);
`endif
        bus.mem_wr_en = 1'b0;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd.wb", 32'(bus.alu_data_1), 16'h0055);
`else
        check("fwd.wb", 32'(bus.alu_data_1), 16'h1111);
`endif
        bus.mem_wr_en = 1'b1; bus.mem_rd = 3'd0; bus.mem_result = 16'hFFFF; bus.wb_wr_en = 1'b0;
        #1;
        check("fwd.mem_r0", 32'(bus.alu_data_1), 16'h1111);
        bus.mem_rd = 3'd5; bus.mem_result = 16'h0BBB;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("fwd.rt", 32'(bus.alu_data_2), 16'h0BBB);
`else
        check("fwd.rt", 32'(bus.alu_data_2), 16'h2222);
`endif
        idle();
        tick();

        // Load-use: LW r3 in EX, ADD r4 = r3 + r1 in ID
        drive(4'h1, 3'd1, 3'd0, 3'd3, 16'h0100, 16'h0000, 16'h0000);
        tick();
        drive(4'h7, 3'd3, 3'd1, 3'd4, 16'hDEAD, 16'h0001, 16'h0000);
        #1;
        check("lu.stall1", 32'(bus.id_stall), 1);
        tick();
        check("lu.bubble", 32'(bus.ex_valid), 0);
        bus.mem_load = 1'b1; bus.mem_rd = 3'd3;
        #1;
`ifdef ID_EX_FORWARD_EN
        check("lu.stall2", 32'(bus.id_stall), 0);
        tick();
        bus.mem_load = 1'b0; bus.mem_rd = '0; bus.id_valid = 1'b0;
        bus.wb_wr_en = 1'b1; bus.wb_rd = 3'd3; bus.wb_result = 16'hBEEF;
        #1;
`else
        check("lu.stall2", 32'(bus.id_stall), 1);
        tick();
        bus.mem_load = 1'b0; bus.mem_rd = '0;
        bus.wb_wr_en = 1'b1; bus.wb_rd = 3'd3; bus.wb_result = 16'hBEEF;
        bus.id_rs_data = 16'hBEEF;
        #1;
        check("lu.stall3", 32'(bus.id_stall), 0);
        tick();
        idle();
        #1;
`endif
        check("lu.ex_valid", 32'(bus.ex_valid), 1);
        check("lu.alu_data_1", 32'(bus.alu_data_1), 16'hBEEF);
        check("lu.alu_data_2", 32'(bus.alu_data_2), 16'h0001);
        idle();
        tick();

        // Flush during a load-use stall, then ADDI with negative immediate
        drive(4'h1, 3'd1, 3'd0, 3'd3, 16'h0100, 16'h0000, 16'h0000);
        tick();
        drive(4'h7, 3'd3, 3'd1, 3'd4, 16'h0000, 16'h0001, 16'h0000);
        #1;
        check("fl.stall_before", 32'(bus.id_stall), 1);
        bus.flush = 1'b1;
        #1;
        check("fl.stall", 32'(bus.id_stall), 0);
        tick();
        bus.flush = 1'b0;
        check("fl.ex_valid", 32'(bus.ex_valid), 0);
        check("fl.alu_sel", 32'(bus.alu_sel), 0);
        check("fl.ex_wr_en", 32'(bus.ex_wr_en), 0);
        drive(4'hC, 3'd1, 3'd0, 3'd2, 16'h0010, 16'h0000, 16'hFFFE);
        #1;
        check("fl.stall_after", 32'(bus.id_stall), 0);
        tick();
        check("addi.alu_sel", 32'(bus.alu_sel), 7);
        check("addi.alu_data_2", 32'(bus.alu_data_2), 16'hFFFE);
        idle();
        tick();

        // Back-to-back RAW: ADD r1 = r2 + r3, then SUB r5 = r1 - r2
        drive(4'h7, 3'd2, 3'd3, 3'd1, 16'h0040, 16'h0002, 16'h0000);
        tick();
        drive(4'h8, 3'd1, 3'd2, 3'd5, 16'h0000, 16'h0040, 16'h0000);
        #1;
`ifdef ID_EX_FORWARD_EN
        check("raw.stall1", 32'(bus.id_stall), 0);
        tick();
        idle();
        bus.mem_wr_en = 1'b1; bus.mem_rd = 3'd1; bus.mem_result = 16'h0042;
        #1;
`else
        check("raw.stall1", 32'(bus.id_stall), 1);
        tick();
        bus.mem_wr_en = 1'b1; bus.mem_rd = 3'd1; bus.mem_result = 16'h0042;
        #1;
        check("raw.stall2", 32'(bus.id_stall), 1);
        tick();
        bus.mem_wr_en = 1'b0; bus.mem_rd = '0;
        bus.wb_wr_en = 1'b1; bus.wb_rd = 3'd1; bus.wb_result = 16'h0042;
        bus.id_rs_data = 16'h0042;
        #1;
        check("raw.stall3", 32'(bus.id_stall), 0);
        tick();
        idle();
        #1;
`endif
        check("raw.ex_opcode", 32'(bus.ex_opcode), 8);
        check("raw.alu_sel", 32'(bus.alu_sel), 8);
        check("raw.alu_data_1", 32'(bus.alu_data_1), 16'h0042);
        check("raw.alu_data_2", 32'(bus.alu_data_2), 16'h0040);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
